// File: rtl/matrix_pkg.sv
// Shared definitions for the 3x3 matrix loader and the downstream result serializer.
package matrix_pkg;

    localparam int unsigned DW       = 8;
    localparam int unsigned N        = 3;
    localparam int unsigned NUM_ELEM = 2 * N * N;
    localparam int unsigned IDX_W    = 5;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Row-major flat index of element (r,c) within one N x N matrix.
    function automatic int unsigned idx(input int unsigned r, input int unsigned c);
        return N * r + c;
    endfunction

endpackage

// File: rtl/matrix_loader_operand_regfile.sv
// Operand storage: 2*N*N elements written one at a time, exposed as two flat matrix buses.
module operand_regfile
    import matrix_pkg::IDX_W;
    import matrix_pkg::idx;
#(
    parameter int unsigned DW = matrix_pkg::DW,
    parameter int unsigned N  = matrix_pkg::N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [IDX_W-1:0]     addr,
    input  logic [DW-1:0]        wdata,
    output logic [N*N*DW-1:0]    a_flat,
    output logic [N*N*DW-1:0]    b_flat
);

    localparam int unsigned MAT   = N * N;
    localparam int unsigned DEPTH = 2 * MAT;

    logic [DW-1:0] mem [DEPTH];

    // Element storage; reset clears every operand and beats a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr == IDX_W'(i)) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    // Stream order is row-major, so element (r,c) of A sits at idx(r,c) and B follows A.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            localparam int unsigned K = idx(r, c);
            assign a_flat[DW*K +: DW] = mem[K];
            assign b_flat[DW*K +: DW] = mem[MAT + K];
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Feeds 18 streamed operands to the 3x3 MAC-array multiplier, pulses Load and tracks Done.
module matrix_loader
    import matrix_pkg::IDX_W;
    import matrix_pkg::NUM_ELEM;
    import matrix_pkg::state_t;
    import matrix_pkg::FILL;
    import matrix_pkg::ISSUE;
    import matrix_pkg::ACK;
    import matrix_pkg::WAIT;
#(
    parameter int unsigned DW          = matrix_pkg::DW,
    parameter int unsigned N           = matrix_pkg::N,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*N*DW-1:0]    A_flat,
    output logic [N*N*DW-1:0]    B_flat,
    output logic                 mat_load,
    input  logic                 mat_done,
    output logic                 busy,
    output logic                 result_valid,
    output logic [IDX_W-1:0]     elem_idx,
    output logic                 timeout_err
);

    // The element counter, operand map and multiplier interface are all fixed at 3x3.
    if (N != 3) begin : g_bad_n
        $error("matrix_loader: only N=3 is supported");
    end

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               busy_nxt;
    logic               load_nxt;
    logic               rv_nxt;
    logic               ready_nxt;
    logic               tmo_nxt;
    logic               wr_en_c;
    logic               xfer_c;
    logic               last_c;
    logic               expired_c;

    assign xfer_c    = in_valid && in_ready;
    assign last_c    = (elem_idx == LAST_IDX);
    assign expired_c = (cnt == CNT_W'(ACK_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ACK gives up after ACK_TIMEOUT cycles without Done falling.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (xfer_c && last_c) state_nxt = ISSUE;
            ISSUE:   if (mat_done) state_nxt = ACK;
            ACK: begin
                if (!mat_done) begin
                    state_nxt = WAIT;
                end else if (expired_c) begin
                    state_nxt = FILL;
                end
            end
            WAIT:    if (mat_done) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Output and counter next values; Load and in_ready follow the next state so they are registered.
    always_comb begin
        idx_nxt   = elem_idx;
        cnt_nxt   = '0;
        busy_nxt  = busy;
        tmo_nxt   = timeout_err;
        rv_nxt    = 1'b0;
        wr_en_c   = 1'b0;
        load_nxt  = (state_nxt == ACK);
        ready_nxt = (state_nxt == FILL);
        case (state)
            FILL: begin
                if (xfer_c) begin
                    wr_en_c  = 1'b1;
                    busy_nxt = 1'b1;
                    idx_nxt  = last_c ? '0 : elem_idx + IDX_W'(1);
                end
            end
            ACK: begin
                if (mat_done) begin
                    if (expired_c) begin
                        tmo_nxt  = 1'b1;
                        busy_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (mat_done) begin
                    rv_nxt   = 1'b1;
                    busy_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and counters; in_ready comes out of reset already high.
    always_ff @(posedge clk) begin
        if (Reset) begin
            in_ready     <= 1'b1;
            mat_load     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            elem_idx     <= '0;
            cnt          <= '0;
        end else begin
            in_ready     <= ready_nxt;
            mat_load     <= load_nxt;
            busy         <= busy_nxt;
            result_valid <= rv_nxt;
            timeout_err  <= tmo_nxt;
            elem_idx     <= idx_nxt;
            cnt          <= cnt_nxt;
        end
    end

    operand_regfile #(
        .DW (DW),
        .N  (N)
    ) u_regfile (
        .clk    (clk),
        .rst    (Reset),
        .we     (wr_en_c),
        .addr   (elem_idx),
        .wdata  (in_data),
        .a_flat (A_flat),
        .b_flat (B_flat)
    );

endmodule
